// File: rtl/msk_pkg.sv
// Shared MSK definitions: unmask FSM states, share layout, counter sizing.
// Used by the serial unmask block and the share encoders.
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

package msk_pkg;

   localparam int DEFAULT_SHARES = `DEFAULTSHARES;

   typedef enum logic [1:0] {
      IDLE,
      FOLD,
      DONE
   } msk_unmask_state_t;

   function automatic int share_bit_idx(input int b, input int s, input int d);
      return b * d + s;
   endfunction

   // share counter width, never below one bit
   function automatic int idx_width(input int d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction

endpackage

// File: rtl/msk_share_sel.sv
// Combinational pick of one share (all count bits) out of a packed sharing.
// Out-of-range indices return zero.
module msk_share_sel
   import msk_pkg::*;
#(
   parameter int d     = 2,
   parameter int count = 1,
   parameter int iw    = 1
) (
   input  logic [count*d-1:0] sh,
   input  logic [iw-1:0]      idx,
   output logic [count-1:0]   sel
);

   always_comb begin
      sel = '0;
      for (int b = 0; b < count; b++) begin
         for (int s = 0; s < d; s++) begin
            if (idx == iw'(s))
               sel[b] = sh[share_bit_idx(b, s, d)];
         end
      end
   end

endmodule

// File: rtl/msk_unmask_serial.sv
// Serial recombination of a d-share Boolean sharing, one share per cycle.
// Each consumed share is wiped from the holding register as it is folded.
module msk_unmask_serial
   import msk_pkg::*;
#(
   parameter int d     = DEFAULT_SHARES,
   parameter int count = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [count*d-1:0] in_sh,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [count-1:0]   out_clear,
   output logic               busy
);

   localparam int IW = idx_width(d);

   msk_unmask_state_t state_q, state_d;

   logic [count*d-1:0] sh_reg;
   logic [count-1:0]   acc;
   logic [count-1:0]   sel;
   logic [IW-1:0]      idx;
   logic               alive;
   logic               last;

   assign last = (idx == IW'(d - 1));

   msk_share_sel #(
      .d    (d),
      .count(count),
      .iw   (IW)
   ) u_sel (
      .sh (sh_reg),
      .idx(idx),
      .sel(sel)
   );

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = alive;
            if (in_valid && alive)
               state_d = FOLD;
         end
         FOLD: begin
            if (last)
               state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // partial sums never leave the block
   assign out_clear = out_valid ? acc : '0;
   assign busy      = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sh_reg  <= '0;
         acc     <= '0;
         idx     <= '0;
         alive   <= 1'b0;
      end else begin
         alive   <= 1'b1;
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (in_valid && alive) begin
                  sh_reg <= in_sh;
                  acc    <= '0;
                  idx    <= '0;
               end
            end
            FOLD: begin
               acc <= acc ^ sel;
               idx <= last ? '0 : idx + 1'b1;
               for (int b = 0; b < count; b++) begin
                  for (int s = 0; s < d; s++) begin
                     if (idx == IW'(s))
                        sh_reg[share_bit_idx(b, s, d)] <= 1'b0;
                  end
               end
            end
            DONE: begin
               if (out_ready)
                  acc <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule
